// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, default widths and helpers for the round-robin resource pool
package arb_pkg;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_BUSY = 1'b1
    } slot_state_e;

    // Ceiling log2, clamped to 1 so index fields never collapse to zero width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

    localparam int DEF_PORTS_N = 8;
    localparam int DEF_GNTS_N  = 2;
    localparam int DEF_PORT_W  = clog2(DEF_PORTS_N);
    localparam int DEF_GNTS_W  = clog2(DEF_GNTS_N);

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating first-one finder starting at a pointer
module rr_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec_in,
    input  logic [W-1:0] start_in,
    output logic [N-1:0] pick_out,
    output logic [W-1:0] idx_out,
    output logic         valid_out
);

    logic [W:0] pos;

    always_comb begin
        pick_out  = '0;
        idx_out   = '0;
        valid_out = 1'b0;
        pos       = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, start_in} + (W+1)'(i);
            if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
            if (!valid_out && vec_in[pos[W-1:0]]) begin
                valid_out             = 1'b1;
                pick_out[pos[W-1:0]]  = 1'b1;
                idx_out               = pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/arb_rr_pool.sv
// rtl/arb_rr_pool.sv - multi-grant round-robin arbiter sharing a pool of resources
module arb_rr_pool
    import arb_pkg::*;
#(
    parameter int PORTS_N  = DEF_PORTS_N,
    parameter int GNTS_N   = DEF_GNTS_N,
    parameter int GNTS_W   = DEF_GNTS_W,
    parameter int PORT_W   = DEF_PORT_W,
    parameter int HOLD_MAX = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PORTS_N-1:0]        req_in,
    output logic [PORTS_N-1:0]        gnt_out,
    output logic [PORTS_N*GNTS_W-1:0] gnt_id_out,
    output logic [PORTS_N-1:0]        preempt_out,
    output logic [GNTS_N-1:0]         busy_out,
    output logic                      full_out
);

    localparam int HOLD_W = (HOLD_MAX > 0) ? clog2(HOLD_MAX + 1) : 1;

    slot_state_e               state_q  [GNTS_N];
    slot_state_e               state_d  [GNTS_N];
    logic [PORT_W-1:0]         owner_q  [GNTS_N];
    logic [PORT_W-1:0]         owner_d  [GNTS_N];
    logic [HOLD_W-1:0]         hold_q   [GNTS_N];
    logic [HOLD_W-1:0]         hold_d   [GNTS_N];
    logic [PORT_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PORTS_N-1:0]        gnt_q, gnt_d;
    logic [PORTS_N*GNTS_W-1:0] gnt_id_q, gnt_id_d;
    logic [PORTS_N-1:0]        preempt_q, preempt_d;

    logic [PORTS_N-1:0] cand     [GNTS_N];
    logic [PORTS_N-1:0] pick_oh  [GNTS_N];
    logic [PORT_W-1:0]  pick_idx [GNTS_N];
    logic               pick_vld [GNTS_N];

    // Each stage sees the candidates left after earlier stages, so picks come out in scan order.
    assign cand[0] = req_in & ~gnt_q;

    for (genvar g = 0; g < GNTS_N; g++) begin : g_pick
        rr_pick #(.N(PORTS_N), .W(PORT_W)) u_pick (
            .vec_in    (cand[g]),
            .start_in  (rr_ptr_q),
            .pick_out  (pick_oh[g]),
            .idx_out   (pick_idx[g]),
            .valid_out (pick_vld[g])
        );
        if (g + 1 < GNTS_N) begin : g_mask
            assign cand[g+1] = cand[g] & ~pick_oh[g];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < GNTS_N; s++) begin
                state_q[s] <= SLOT_IDLE;
                owner_q[s] <= '0;
                hold_q[s]  <= '0;
            end
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            preempt_q <= '0;
        end else begin
            for (int s = 0; s < GNTS_N; s++) begin
                state_q[s] <= state_d[s];
                owner_q[s] <= owner_d[s];
                hold_q[s]  <= hold_d[s];
            end
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            preempt_q <= preempt_d;
        end
    end

    logic               waiting;
    logic               pre_done;
    logic               any_grant;
    logic [GNTS_W:0]    k;
    logic [PORT_W-1:0]  last_idx;
    logic [PORT_W-1:0]  pre_port;

    // Release, preemption and allocation all look only at pre-edge state; a slot freed
    // on this edge is still IDLE-in-waiting and cannot be handed out until the next one.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_id_d  = gnt_id_q;
        preempt_d = '0;
        gnt_d     = '0;
        pre_done  = 1'b0;
        any_grant = 1'b0;
        k         = '0;
        last_idx  = '0;
        pre_port  = '0;
        waiting   = |(req_in & ~gnt_q);
        for (int s = 0; s < GNTS_N; s++) begin
            if (state_q[s] == SLOT_BUSY) begin
                if (!req_in[owner_q[s]]) begin
                    state_d[s] = SLOT_IDLE;
                end else if ((HOLD_MAX > 0) && (hold_q[s] == HOLD_W'(HOLD_MAX))
                             && waiting && !pre_done) begin
                    state_d[s]             = SLOT_IDLE;
                    preempt_d[owner_q[s]]  = 1'b1;
                    pre_done               = 1'b1;
                    pre_port               = owner_q[s];
                end else if (hold_q[s] != HOLD_W'(HOLD_MAX)) begin
                    hold_d[s] = hold_q[s] + HOLD_W'(1);
                end
            end else if ((k < (GNTS_W+1)'(GNTS_N)) && pick_vld[k[GNTS_W-1:0]]) begin
                state_d[s] = SLOT_BUSY;
                owner_d[s] = pick_idx[k[GNTS_W-1:0]];
                hold_d[s]  = '0;
                gnt_id_d[pick_idx[k[GNTS_W-1:0]]*GNTS_W +: GNTS_W] = GNTS_W'(s);
                last_idx   = pick_idx[k[GNTS_W-1:0]];
                any_grant  = 1'b1;
                k          = k + 1'b1;
            end
        end
        if (any_grant) rr_ptr_d = PORT_W'(wrap_inc(int'(last_idx), PORTS_N));
        // A preemption restarts the scan just past the evicted owner, overriding the grant pointer.
        if (pre_done)  rr_ptr_d = PORT_W'(wrap_inc(int'(pre_port), PORTS_N));
        for (int s = 0; s < GNTS_N; s++) begin
            if (state_d[s] == SLOT_BUSY) gnt_d[owner_d[s]] = 1'b1;
        end
    end

    always_comb begin
        busy_out = '0;
        for (int s = 0; s < GNTS_N; s++) begin
            busy_out[s] = (state_q[s] == SLOT_BUSY);
        end
        full_out    = &busy_out;
        gnt_out     = gnt_q;
        gnt_id_out  = gnt_id_q;
        preempt_out = preempt_q;
    end

endmodule

// File: tb/tb_arb_rr_pool.sv
// tb/tb_arb_rr_pool.sv - directed self-checking bench for arb_rr_pool
module tb_arb_rr_pool;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = '0;

    logic [7:0] gnt0, id0, pre0, gnt1, id1, pre1;
    logic [1:0] busy0, busy1;
    logic       full0, full1;

    always #5 clk = ~clk;

    arb_rr_pool #(.PORTS_N(8), .GNTS_N(2), .GNTS_W(1), .PORT_W(3), .HOLD_MAX(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_in(req), .gnt_out(gnt0), .gnt_id_out(id0),
        .preempt_out(pre0), .busy_out(busy0), .full_out(full0)
    );

    arb_rr_pool #(.PORTS_N(8), .GNTS_N(2), .GNTS_W(1), .PORT_W(3), .HOLD_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset), .req_in(req), .gnt_out(gnt1), .gnt_id_out(id1),
        .preempt_out(pre1), .busy_out(busy1), .full_out(full1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        bit         sel;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [7:0] pre;
        logic [1:0] busy;
        int         id_port;
        logic       id_val;
    } vec_t;

    vec_t tv [22];

    initial begin
        logic [7:0] g, p, newg, prev;
        logic [1:0] b;
        logic       f;
        logic [7:0] ids;
        int         exp_port, n;
        int         cnt [8];

        // case 1/2 on HOLD_MAX=0 instance
        tv[0]  = '{1, 0, 8'h05, 8'h05, 8'h00, 2'b11, 0, 1'b0};
        tv[1]  = '{0, 0, 8'h25, 8'h05, 8'h00, 2'b11, 2, 1'b1};
        tv[2]  = '{0, 0, 8'h24, 8'h04, 8'h00, 2'b10, -1, 1'b0};
        tv[3]  = '{0, 0, 8'h24, 8'h24, 8'h00, 2'b11, 5, 1'b0};
        tv[4]  = '{0, 0, 8'h00, 8'h00, 8'h00, 2'b00, -1, 1'b0};
        tv[5]  = '{0, 0, 8'h00, 8'h00, 8'h00, 2'b00, -1, 1'b0};
        // case 4: hold limit 4, ports 1/3 hold, port 6 waits
        tv[6]  = '{1, 1, 8'h0A, 8'h0A, 8'h00, 2'b11, 1, 1'b0};
        tv[7]  = '{0, 1, 8'h4A, 8'h0A, 8'h00, 2'b11, 3, 1'b1};
        tv[8]  = '{0, 1, 8'h4A, 8'h0A, 8'h00, 2'b11, -1, 1'b0};
        tv[9]  = '{0, 1, 8'h4A, 8'h0A, 8'h00, 2'b11, -1, 1'b0};
        tv[10] = '{0, 1, 8'h4A, 8'h0A, 8'h00, 2'b11, -1, 1'b0};
        tv[11] = '{0, 1, 8'h4A, 8'h08, 8'h02, 2'b10, -1, 1'b0};
        tv[12] = '{0, 1, 8'h4A, 8'h40, 8'h08, 2'b01, 6, 1'b0};
        tv[13] = '{0, 1, 8'h4A, 8'h42, 8'h00, 2'b11, 1, 1'b1};
        // case 5: release + preemption + new request on one edge
        tv[14] = '{1, 1, 8'h0C, 8'h0C, 8'h00, 2'b11, 2, 1'b0};
        tv[15] = '{0, 1, 8'h0D, 8'h0C, 8'h00, 2'b11, 3, 1'b1};
        tv[16] = '{0, 1, 8'h0D, 8'h0C, 8'h00, 2'b11, -1, 1'b0};
        tv[17] = '{0, 1, 8'h0D, 8'h0C, 8'h00, 2'b11, -1, 1'b0};
        tv[18] = '{0, 1, 8'h0D, 8'h0C, 8'h00, 2'b11, -1, 1'b0};
        tv[19] = '{0, 1, 8'h19, 8'h00, 8'h08, 2'b00, -1, 1'b0};
        tv[20] = '{0, 1, 8'h19, 8'h11, 8'h00, 2'b11, 4, 1'b0};
        tv[21] = '{0, 1, 8'h19, 8'h11, 8'h00, 2'b11, 0, 1'b1};

        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset gnt", gnt0, 8'h00);
        chk("reset id", id0, 8'h00);
        chk("reset busy/full", {busy0, full0}, 3'b000);
        chk("reset preempt", pre1, 8'h00);
        chk("reset rr_ptr", u_dut0.rr_ptr_q, 3'd0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            if (tv[i].rst) do_reset();
            req = tv[i].req;
            @(posedge clk);
            #1;
            g   = tv[i].sel ? gnt1 : gnt0;
            p   = tv[i].sel ? pre1 : pre0;
            b   = tv[i].sel ? busy1 : busy0;
            f   = tv[i].sel ? full1 : full0;
            ids = tv[i].sel ? id1 : id0;
            chk($sformatf("row%0d gnt", i), g, tv[i].gnt);
            chk($sformatf("row%0d preempt", i), p, tv[i].pre);
            chk($sformatf("row%0d busy", i), b, tv[i].busy);
            chk($sformatf("row%0d full", i), f, &tv[i].busy);
            if (tv[i].id_port >= 0)
                chk($sformatf("row%0d id[%0d]", i, tv[i].id_port), ids[tv[i].id_port], tv[i].id_val);
            if (i == 0) chk("case1 rr_ptr", u_dut0.rr_ptr_q, 3'd3);
        end

        // fairness: everyone requests, each drops for one cycle after its grant
        do_reset();
        req      = 8'hFF;
        prev     = '0;
        exp_port = 0;
        n        = 0;
        for (int q = 0; q < 8; q++) cnt[q] = 0;
        for (int cyc = 0; cyc < 40 && n < 16; cyc++) begin
            @(posedge clk);
            #1;
            newg = gnt0 & ~prev;
            for (int s = 0; s < 2; s++) begin
                for (int q = 0; q < 8; q++) begin
                    if (newg[q] && id0[q] == s[0]) begin
                        chk("fair order", q, exp_port);
                        exp_port = (exp_port + 1) % 8;
                        n++;
                        cnt[q]++;
                    end
                end
            end
            prev = gnt0;
            req  = 8'hFF & ~gnt0;
        end
        chk("fair total", n, 16);
        for (int q = 0; q < 8; q++) chk($sformatf("fair count p%0d", q), cnt[q], 2);

        // asynchronous reset mid-operation, then replay case 1
        do_reset();
        req = 8'h03;
        @(posedge clk);
        #1;
        chk("pre-reset gnt", gnt0, 8'h03);
        #3;
        reset = 1'b1;
        #1;
        chk("async reset gnt0", gnt0, 8'h00);
        chk("async reset gnt1", gnt1, 8'h00);
        chk("async reset busy/full", {busy0, full0}, 3'b000);
        chk("async reset preempt", pre0 | pre1, 8'h00);
        req = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req = 8'h05;
        @(posedge clk);
        #1;
        chk("replay gnt", gnt0, 8'h05);
        chk("replay id0", id0[0], 1'b0);
        chk("replay id2", id0[2], 1'b1);
        chk("replay full", full0, 1'b1);
        chk("replay rr_ptr", u_dut0.rr_ptr_q, 3'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
